bcd_step_checker: RTL and testbench

Sequential monitor on the consumer side of the BCD up/down counter's `count` bus. It samples the 4-bit BCD digit each enabled clock and infers the counting direction. It also verifies that every step is a legal ±1 (mod 10) transition and reports wrap-around, direction reversals and errors. A saturating 2-digit BCD error counter gives a running health figure for the counter under test or in system.

---
 rtl/bcd_step_checker.sv | 107 ++++++++++
 tb/tb_bcd_step_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_checker.sv
// bcd_step_checker: watches a BCD counter digit stream, infers direction, flags illegal codes/steps
// and keeps a saturating two-digit BCD error count.
module bcd_step_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       valid_in,
  input  logic       clear,
  output logic       dir,
  output logic       locked,
  output logic       step_err,
  output logic       code_err,
  output logic       wrap_up,
  output logic       wrap_down,
  output logic       dir_change,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {EMPTY, SEEN, LOCKED} state_t;
  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       dir_q, dir_d;
  logic [7:0] err_q, err_d;
  logic       step_err_q, step_err_d;
  logic       code_err_q, code_err_d;
  logic       wrap_up_q, wrap_up_d;
  logic       wrap_down_q, wrap_down_d;
  logic       dir_change_q, dir_change_d;
  logic [3:0] up_val, dn_val;
  logic       up_ok, dn_ok, legal, err_inc;
  always_comb begin
    up_val       = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
    dn_val       = (prev_q == 4'd0) ? 4'd9 : prev_q - 4'd1;
    up_ok        = count_in == up_val;
    dn_ok        = count_in == dn_val;
    legal        = count_in <= 4'd9;
    state_d      = state_q;
    prev_d       = prev_q;
    dir_d        = dir_q;
    step_err_d   = 1'b0;
    code_err_d   = 1'b0;
    wrap_up_d    = 1'b0;
    wrap_down_d  = 1'b0;
    dir_change_d = 1'b0;
    err_inc      = 1'b0;
    if (clear) begin
      state_d = EMPTY;
      dir_d   = 1'b0;
    end else if (valid_in) begin
      if (!legal) begin
        code_err_d = 1'b1;
        err_inc    = 1'b1;
        state_d    = EMPTY;
      end else begin
        prev_d = count_in;
        if (state_q == EMPTY) begin
          state_d = SEEN;
        end else if (up_ok || dn_ok) begin
          state_d      = LOCKED;
          dir_d        = up_ok;
          dir_change_d = (state_q == LOCKED) && (up_ok != dir_q);
          wrap_up_d    = up_ok && (count_in == 4'd0);
          wrap_down_d  = dn_ok && (count_in == 4'd9);
        end else if (state_q == LOCKED || count_in != prev_q) begin
          // a repeated digit is only a stall while direction is still unknown
          step_err_d = 1'b1;
          err_inc    = 1'b1;
          state_d    = SEEN;
        end
      end
    end
    err_d = clear ? 8'h00
          : (!err_inc || err_q == 8'h99) ? err_q
          : (err_q[3:0] == 4'd9) ? {err_q[7:4] + 4'd1, 4'd0}
          : {err_q[7:4], err_q[3:0] + 4'd1};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      prev_q       <= 4'd0;
      dir_q        <= 1'b0;
      err_q        <= 8'h00;
      step_err_q   <= 1'b0;
      code_err_q   <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_down_q  <= 1'b0;
      dir_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      step_err_q   <= step_err_d;
      code_err_q   <= code_err_d;
      wrap_up_q    <= wrap_up_d;
      wrap_down_q  <= wrap_down_d;
      dir_change_q <= dir_change_d;
    end
  end
  assign dir        = dir_q;
  assign locked     = state_q == LOCKED;
  assign step_err   = step_err_q;
  assign code_err   = code_err_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_down  = wrap_down_q;
  assign dir_change = dir_change_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_bcd_step_checker.sv
// tb_bcd_step_checker: directed test-plan sequences plus random stimulus, checked every cycle
// against an arithmetic model of the step checker.
module tb_bcd_step_checker;
  logic       clk, reset, valid_in, clear;
  logic [3:0] count_in;
  logic       dir, locked, step_err, code_err, wrap_up, wrap_down, dir_change;
  logic [7:0] err_count;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_prev, m_st, m_err;
  bit m_dir, p_step, p_code, p_wu, p_wd, p_dc;

  bcd_step_checker dut (
    .clk(clk), .reset(reset), .count_in(count_in), .valid_in(valid_in), .clear(clear),
    .dir(dir), .locked(locked), .step_err(step_err), .code_err(code_err),
    .wrap_up(wrap_up), .wrap_down(wrap_down), .dir_change(dir_change), .err_count(err_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = 0; m_st = 0; m_err = 0; m_dir = 0;
    p_step = 0; p_code = 0; p_wu = 0; p_wd = 0; p_dc = 0;
  endtask

  task automatic bump();
    if (m_err < 99) m_err++;
  endtask

  // m_st: 0 = nothing held, 1 = one sample held, 2 = locked
  task automatic model_edge(bit v, bit c, int x);
    p_step = 0; p_code = 0; p_wu = 0; p_wd = 0; p_dc = 0;
    if (c) begin
      m_st = 0; m_dir = 0; m_err = 0;
    end else if (v) begin
      if (x > 9) begin
        p_code = 1; bump(); m_st = 0;
      end else if (m_st == 0) begin
        m_prev = x; m_st = 1;
      end else begin
        bit up = (x == (m_prev + 1) % 10);
        bit dn = (x == (m_prev + 9) % 10);
        if (up || dn) begin
          p_dc = (m_st == 2) && (up != m_dir);
          m_dir = up; m_st = 2;
          p_wu = up && x == 0;
          p_wd = dn && x == 9;
        end else if (m_st == 2 || x != m_prev) begin
          p_step = 1; bump(); m_st = 1;
        end
        m_prev = x;
      end
    end
  endtask

  function automatic logic [14:0] expected();
    logic [7:0] e;
    e = {4'(m_err / 10), 4'(m_err % 10)};
    return {m_dir, m_st == 2, p_step, p_code, p_wu, p_wd, p_dc, e};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [14:0] act, exp;
      act = {dir, locked, step_err, code_err, wrap_up, wrap_down, dir_change, err_count};
      exp = expected();
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got dir/lk/se/ce/wu/wd/dc=%b err=%h expected %b err=%h",
                 $time, act[14:8], act[7:0], exp[14:8], exp[7:0]);
      end
    end
  end

  task automatic chk(string name, logic [7:0] a, logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, a, e);
    end
  endtask

  task automatic cyc(bit v, bit c, logic [3:0] x);
    valid_in = v; clear = c; count_in = x;
    @(posedge clk);
    model_edge(v, c, int'(x));
    #1;
  endtask

  task automatic feed(bit gaps, int q[$]);
    foreach (q[i]) begin
      cyc(1, 0, 4'(q[i]));
      if (gaps) cyc(0, 0, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    reset = 0; valid_in = 0; clear = 0; count_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1;
    chk_en = 1;
    #1;
    // up stream
    feed(0, '{0, 1});
    chk("up_locked", 8'(locked), 8'd1);
    chk("up_dir", 8'(dir), 8'd1);
    feed(0, '{2, 3, 4, 5, 6, 7, 8, 9, 0});
    chk("up_wrap", 8'(wrap_up), 8'd1);
    feed(0, '{1});
    chk("up_wrap_once", 8'(wrap_up), 8'd0);
    chk("up_err", err_count, 8'h00);
    // down stream
    cyc(0, 1, 0);
    feed(0, '{3, 2, 1, 0, 9});
    chk("dn_wrap", 8'(wrap_down), 8'd1);
    feed(0, '{8});
    chk("dn_dir", 8'(dir), 8'd0);
    chk("dn_locked", 8'(locked), 8'd1);
    chk("dn_err", err_count, 8'h00);
    // reversal
    cyc(0, 1, 0);
    feed(0, '{4, 5, 6, 5});
    chk("rev_dc", 8'(dir_change), 8'd1);
    chk("rev_dir", 8'(dir), 8'd0);
    feed(0, '{4});
    chk("rev_locked", 8'(locked), 8'd1);
    chk("rev_dc_once", 8'(dir_change), 8'd0);
    // jump and relock, with gaps
    cyc(0, 1, 0);
    feed(1, '{1, 2});
    cyc(1, 0, 7);
    chk("jmp_step_err", 8'(step_err), 8'd1);
    chk("jmp_locked", 8'(locked), 8'd0);
    chk("jmp_err", err_count, 8'h01);
    cyc(0, 0, 3);
    cyc(1, 0, 8);
    chk("jmp_relock", {dir, locked}, 2'b11);
    // illegal codes and saturation
    cyc(0, 1, 0);
    cyc(1, 0, 4'hC);
    chk("ill_code_err", 8'(code_err), 8'd1);
    chk("ill_err", err_count, 8'h01);
    repeat (9) cyc(1, 0, 4'hC);
    chk("ill_err10", err_count, 8'h10);
    repeat (110) cyc(1, 0, 4'($urandom_range(10, 15)));
    chk("ill_sat", err_count, 8'h99);
    cyc(1, 0, 4'hF);
    chk("ill_sat_hold", err_count, 8'h99);
    cyc(1, 1, 4'hF);
    chk("clr_err", err_count, 8'h00);
    chk("clr_no_code_err", 8'(code_err), 8'd0);
    chk("clr_locked", 8'(locked), 8'd0);
    // async reset while locked with five errors
    repeat (5) cyc(1, 0, 4'hA);
    feed(0, '{1, 2});
    chk("pre_rst", {locked, err_count}, 9'h105);
    #2 reset = 0;
    model_reset();
    #1;
    chk("async_rst", {dir, locked, step_err, code_err, wrap_up, wrap_down, dir_change, err_count}, 8'h00);
    @(negedge clk); #1 reset = 1;
    cyc(1, 0, 7);
    chk("post_rst_first", {locked, step_err, err_count}, 8'h00);
    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      int r, k, x;
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      x = k < 4 ? (m_prev + 1) % 10 : k < 7 ? (m_prev + 9) % 10 : k == 7 ? m_prev
        : k == 8 ? $urandom_range(0, 9) : $urandom_range(10, 15);
      cyc(r < 85, r < 2, 4'(x));
    end
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
